// File: rtl/exc_collect.sv
// exc_collect: exception collection and commit stage ahead of the CP0 register file.
//
// Carries one exception tag per instruction through the ID, EX and MEM stages.
// At the MEM boundary it commits one precise exception, interrupt or ERET.
// After a commit it flushes the pipeline and then redirects fetch.
//
// Optional macro:
//   EXC_INT_EN  when defined, int_req (masked by cp0_exl) is taken at the commit
//               point as ExcCode 0. When undefined, interrupts are ignored.
//
// Ports:
//   clk, rstn                        clock, synchronous active-low reset
//   stall                            holds the tag registers
//   if_valid/if_pc/if_adel           fetch-stage instruction and fetch address error
//   id_ri/id_sys/id_bp/id_eret       decode-stage exceptions and eret
//   id_in_ds                         decode-stage instruction is in a delay slot
//   ex_ov                            execute-stage overflow
//   mem_adel/mem_ades/mem_badvaddr   memory-stage address errors and faulting address
//   int_req, cp0_exl, epc_in         CP0 interrupt request, STATUS.EXL and EPC
//   exc_commit/eret_commit           one-cycle commit pulses to CP0
//   exc_code/exc_epc/exc_bd/exc_badvaddr   exception details, valid with exc_commit
//   flush                            kill IF..MEM
//   redirect_valid/redirect_pc       one-cycle fetch redirect
//   busy                             a commit is being processed
//
// state      | meaning
// -----------+---------------------------------------------------------
// S_IDLE     | tags flow through the pipeline; commit decision is made
// S_FLUSH    | flush held for FLUSH_CYCLES cycles; tags forced invalid
// S_REDIRECT | one-cycle redirect to EXC_VECTOR or the latched EPC

module exc_collect #(
   parameter logic [31:0] EXC_VECTOR   = 32'hBFC00380,
   parameter int unsigned FLUSH_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        stall,
   input  logic        if_valid,
   input  logic [31:0] if_pc,
   input  logic        if_adel,
   input  logic        id_ri,
   input  logic        id_sys,
   input  logic        id_bp,
   input  logic        id_eret,
   input  logic        id_in_ds,
   input  logic        ex_ov,
   input  logic        mem_adel,
   input  logic        mem_ades,
   input  logic [31:0] mem_badvaddr,
   input  logic        int_req,
   input  logic        cp0_exl,
   input  logic [31:0] epc_in,
   output logic        exc_commit,
   output logic        eret_commit,
   output logic [4:0]  exc_code,
   output logic [31:0] exc_epc,
   output logic        exc_bd,
   output logic [31:0] exc_badvaddr,
   output logic        flush,
   output logic        redirect_valid,
   output logic [31:0] redirect_pc,
   output logic        busy
);

   typedef struct packed {
      logic        valid;
      logic [31:0] pc;
      logic        bd;
      logic        has_exc;
      logic [4:0]  code;
      logic [31:0] badvaddr;
      logic        eret;
   } tag_t;

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_FLUSH    = 2'd1,
      S_REDIRECT = 2'd2
   } state_t;

   localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

   tag_t   id_q, ex_q, mem_q;
   tag_t   id_d, ex_d, mem_d, mem_m;
   state_t state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [31:0] target_q;
   logic        int_take, exc_take, eret_take, commit, idle;

   logic        exc_commit_q, eret_commit_q, exc_bd_q;
   logic [4:0]  exc_code_q;
   logic [31:0] exc_epc_q, exc_badvaddr_q;

`ifdef EXC_INT_EN
   assign int_take = int_req & ~cp0_exl;
`else
   // Interrupt inputs are intentionally not consumed in this build.
   logic unused_int;
   assign unused_int = int_req ^ cp0_exl;
   assign int_take   = 1'b0;
`endif

   // Each stage merge only fills code/badvaddr when no earlier stage already did.
   always_comb begin
      id_d          = '0;
      id_d.valid    = if_valid;
      id_d.pc       = if_pc;
      if (if_adel) begin
         id_d.has_exc  = 1'b1;
         id_d.code     = 5'd4;
         id_d.badvaddr = if_pc;
      end

      ex_d      = id_q;
      ex_d.bd   = id_in_ds;
      ex_d.eret = id_eret;
      if (!id_q.has_exc && (id_ri || id_sys || id_bp)) begin
         ex_d.has_exc = 1'b1;
         ex_d.code    = id_ri ? 5'd10 : (id_sys ? 5'd8 : 5'd9);
      end

      mem_d = ex_q;
      if (!ex_q.has_exc && ex_ov) begin
         mem_d.has_exc = 1'b1;
         mem_d.code    = 5'd12;
      end

      mem_m = mem_q;
      if (!mem_q.has_exc && (mem_adel || mem_ades)) begin
         mem_m.has_exc  = 1'b1;
         mem_m.code     = mem_adel ? 5'd4 : 5'd5;
         mem_m.badvaddr = mem_badvaddr;
      end
   end

   assign idle      = (state_q == S_IDLE);
   assign exc_take  = idle & mem_m.valid & (int_take | mem_m.has_exc);
   assign eret_take = idle & mem_m.valid & ~int_take & ~mem_m.has_exc & mem_m.eret;
   assign commit    = exc_take | eret_take;

   always_ff @(posedge clk) begin
      if (!rstn || commit || !idle) begin
         id_q  <= '0;
         ex_q  <= '0;
         mem_q <= '0;
      end else if (!stall) begin
         id_q  <= id_d;
         ex_q  <= ex_d;
         mem_q <= mem_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_IDLE: begin
            if (commit) begin
               state_d = S_FLUSH;
               cnt_d   = FLUSH_LOAD;
            end
         end
         S_FLUSH: begin
            if (cnt_q == 4'd0) state_d = S_REDIRECT;
            else               cnt_d   = cnt_q - 4'd1;
         end
         S_REDIRECT: state_d = S_IDLE;
         default:    state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q <= S_IDLE;
         cnt_q   <= 4'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         exc_commit_q   <= 1'b0;
         eret_commit_q  <= 1'b0;
         exc_code_q     <= 5'd0;
         exc_epc_q      <= 32'd0;
         exc_bd_q       <= 1'b0;
         exc_badvaddr_q <= 32'd0;
         target_q       <= 32'd0;
      end else begin
         exc_commit_q  <= exc_take;
         eret_commit_q <= eret_take;
         if (exc_take) begin
            exc_code_q     <= int_take ? 5'd0 : mem_m.code;
            exc_epc_q      <= mem_m.bd ? (mem_m.pc - 32'd4) : mem_m.pc;
            exc_bd_q       <= mem_m.bd;
            exc_badvaddr_q <= mem_m.badvaddr;
            target_q       <= EXC_VECTOR;
         end else if (eret_take) begin
            target_q       <= epc_in;
         end
      end
   end

   assign exc_commit     = exc_commit_q;
   assign eret_commit    = eret_commit_q;
   assign exc_code       = exc_code_q;
   assign exc_epc        = exc_epc_q;
   assign exc_bd         = exc_bd_q;
   assign exc_badvaddr   = exc_badvaddr_q;
   assign flush          = (state_q == S_FLUSH);
   assign redirect_valid = (state_q == S_REDIRECT);
   assign redirect_pc    = redirect_valid ? target_q : 32'd0;
   assign busy           = ~idle;

endmodule

// File: tb/tb_exc_collect.sv
// Testbench for exc_collect: directed scenarios plus randomized traffic, all
// checked every cycle against an instruction-level model of the commit rules.
module tb_exc_collect;

   localparam int          F   = 2;
   localparam logic [31:0] VEC = 32'hBFC00380;
`ifdef EXC_INT_EN
   localparam bit INT_EN = 1'b1;
`else
   localparam bit INT_EN = 1'b0;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rstn, stall, if_valid, if_adel;
   logic [31:0] if_pc, mem_badvaddr, epc_in;
   logic        id_ri, id_sys, id_bp, id_eret, id_in_ds, ex_ov;
   logic        mem_adel, mem_ades, int_req, cp0_exl;
   logic        exc_commit, eret_commit, exc_bd, flush, redirect_valid, busy;
   logic [4:0]  exc_code;
   logic [31:0] exc_epc, exc_badvaddr, redirect_pc;

   exc_collect #(.EXC_VECTOR(VEC), .FLUSH_CYCLES(F)) dut (
      .clk(clk), .rstn(rstn), .stall(stall),
      .if_valid(if_valid), .if_pc(if_pc), .if_adel(if_adel),
      .id_ri(id_ri), .id_sys(id_sys), .id_bp(id_bp), .id_eret(id_eret),
      .id_in_ds(id_in_ds), .ex_ov(ex_ov),
      .mem_adel(mem_adel), .mem_ades(mem_ades), .mem_badvaddr(mem_badvaddr),
      .int_req(int_req), .cp0_exl(cp0_exl), .epc_in(epc_in),
      .exc_commit(exc_commit), .eret_commit(eret_commit), .exc_code(exc_code),
      .exc_epc(exc_epc), .exc_bd(exc_bd), .exc_badvaddr(exc_badvaddr),
      .flush(flush), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .busy(busy)
   );

   int n_pass = 0;
   int n_total = 0;
   bit chk_en = 1'b0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
   endtask

   // Model: each in-flight instruction remembers the event raised in every stage
   // (index 0=IF,1=ID,2=EX,3=MEM; -1 = none). At MEM the earliest stage with an
   // event decides the cause. Slot 0/1/2 = instruction currently in ID/EX/MEM.
   bit          m_v   [3];
   bit [31:0]   m_pc  [3];
   bit          m_bd  [3];
   bit          m_er  [3];
   int          m_code[3][4];
   bit [31:0]   m_bva [3][4];
   int          busy_cnt;
   bit          e_exc, e_eret, e_bd;
   bit [4:0]    e_code;
   bit [31:0]   e_epc, e_bva, e_tgt;

   function automatic void clear_slots();
      for (int s = 0; s < 3; s++) begin
         m_v[s] = 1'b0; m_pc[s] = '0; m_bd[s] = 1'b0; m_er[s] = 1'b0;
         for (int k = 0; k < 4; k++) begin m_code[s][k] = -1; m_bva[s][k] = '0; end
      end
   endfunction

   always @(posedge clk) begin : model
      int  first;
      bit  intr, done;
      e_exc  = 1'b0;
      e_eret = 1'b0;
      if (!rstn) begin
         clear_slots();
         busy_cnt = 0;
         e_bd = 1'b0; e_code = '0; e_epc = '0; e_bva = '0; e_tgt = '0;
      end else if (busy_cnt > 0) begin
         busy_cnt--;
         clear_slots();
      end else begin
         done = 1'b0;
         if (m_v[2]) begin
            m_code[2][3] = mem_adel ? 4 : (mem_ades ? 5 : -1);
            m_bva[2][3]  = mem_badvaddr;
            first = -1;
            for (int k = 3; k >= 0; k--) if (m_code[2][k] >= 0) first = k;
            intr = INT_EN && int_req && !cp0_exl;
            if (intr || first >= 0) begin
               e_exc  = 1'b1;
               e_code = intr ? 5'd0 : 5'(m_code[2][first]);
               e_bva  = intr ? 32'd0 : m_bva[2][first];
               e_bd   = m_bd[2];
               e_epc  = m_bd[2] ? m_pc[2] - 32'd4 : m_pc[2];
               e_tgt  = VEC;
               done   = 1'b1;
            end else if (m_er[2]) begin
               e_eret = 1'b1;
               e_tgt  = epc_in;
               done   = 1'b1;
            end
         end
         if (done) begin
            busy_cnt = F + 1;
            clear_slots();
         end else if (!stall) begin
            m_v[2] = m_v[1]; m_pc[2] = m_pc[1]; m_bd[2] = m_bd[1]; m_er[2] = m_er[1];
            for (int k = 0; k < 4; k++) begin m_code[2][k] = m_code[1][k]; m_bva[2][k] = m_bva[1][k]; end
            m_code[2][2] = ex_ov ? 12 : -1;
            m_v[1] = m_v[0]; m_pc[1] = m_pc[0]; m_bd[1] = id_in_ds; m_er[1] = id_eret;
            for (int k = 0; k < 4; k++) begin m_code[1][k] = m_code[0][k]; m_bva[1][k] = m_bva[0][k]; end
            m_code[1][1] = id_ri ? 10 : (id_sys ? 8 : (id_bp ? 9 : -1));
            m_bva[1][1]  = '0;
            m_v[0] = if_valid; m_pc[0] = if_pc; m_bd[0] = 1'b0; m_er[0] = 1'b0;
            for (int k = 0; k < 4; k++) begin m_code[0][k] = -1; m_bva[0][k] = '0; end
            m_code[0][0] = if_adel ? 4 : -1;
            m_bva[0][0]  = if_pc;
         end
      end
   end

   always @(negedge clk) begin : compare
      if (chk_en) begin
         check("exc_commit", exc_commit, e_exc);
         check("eret_commit", eret_commit, e_eret);
         check("flush", flush, busy_cnt > 1);
         check("redirect_valid", redirect_valid, busy_cnt == 1);
         check("busy", busy, busy_cnt > 0);
         if (busy_cnt == 1) check("redirect_pc", redirect_pc, e_tgt);
         if (e_exc) begin
            check("exc_code", exc_code, e_code);
            check("exc_epc", exc_epc, e_epc);
            check("exc_bd", exc_bd, e_bd);
            if (e_code != 5'd0) check("exc_badvaddr", exc_badvaddr, e_bva);
         end
      end
   end

   task automatic step();
      @(posedge clk); #2;
   endtask

   task automatic clr_in();
      if_valid = 0; if_adel = 0; id_ri = 0; id_sys = 0; id_bp = 0; id_eret = 0;
      id_in_ds = 0; ex_ov = 0; mem_adel = 0; mem_ades = 0; stall = 0;
   endtask

   // Leaves time at the negedge of the commit cycle.
   task automatic wait_commit();
      bit got = 1'b0;
      for (int i = 0; i < 30 && !got; i++) begin
         @(negedge clk);
         got = exc_commit | eret_commit;
      end
      if (!got) check("commit_timeout", 32'd0, 32'd1);
   endtask

   // From a commit-cycle negedge, counts flush cycles until redirect_valid.
   task automatic wait_redirect(output int nfl);
      bit got = 1'b0;
      nfl = flush ? 1 : 0;
      for (int i = 0; i < 30 && !got; i++) begin
         @(negedge clk);
         if (redirect_valid) got = 1'b1;
         else if (flush) nfl++;
      end
      if (!got) check("redirect_timeout", 32'd0, 32'd1);
   endtask

   initial begin
      int nfl, cnt;
      rstn = 0; clr_in(); if_pc = '0; mem_badvaddr = '0; epc_in = '0;
      int_req = 0; cp0_exl = 0;
      step(); step(); step();
      chk_en = 1'b1;
      @(negedge clk);
      check("rst_exc_commit", exc_commit, 0);
      check("rst_flush", flush, 0);
      check("rst_busy", busy, 0);
      check("rst_redirect_pc", redirect_pc, 0);
      step(); rstn = 1;

      // Fetch address error
      if_valid = 1; if_pc = 32'h00400002; if_adel = 1; step(); clr_in();
      wait_commit();
      check("t1_code", exc_code, 4);
      check("t1_epc", exc_epc, 32'h00400002);
      check("t1_bva", exc_badvaddr, 32'h00400002);
      check("t1_bd", exc_bd, 0);
      wait_redirect(nfl);
      check("t1_flush_cycles", nfl, 2);
      check("t1_redirect_pc", redirect_pc, 32'hBFC00380);
      step();

      // Syscall in a delay slot
      if_valid = 1; if_pc = 32'h00400104; step(); clr_in();
      id_sys = 1; id_in_ds = 1; step(); clr_in();
      wait_commit();
      check("t2_code", exc_code, 8);
      check("t2_bd", exc_bd, 1);
      check("t2_epc", exc_epc, 32'h00400100);
      wait_redirect(nfl);
      step();

      // Earliest stage wins over later overflow
      if_valid = 1; if_pc = 32'h00400300; if_adel = 1; step(); clr_in();
      step(); ex_ov = 1; step(); clr_in();
      wait_commit();
      check("t3_code", exc_code, 4);
      wait_redirect(nfl);
      step();

      // ERET
      epc_in = 32'h00400200;
      if_valid = 1; if_pc = 32'h00400400; step(); clr_in();
      id_eret = 1; step(); clr_in();
      wait_commit();
      check("t4_eret", eret_commit, 1);
      check("t4_exc", exc_commit, 0);
      wait_redirect(nfl);
      check("t4_redirect_pc", redirect_pc, 32'h00400200);
      step();

      // Interrupt versus MEM store error, unmasked then masked by EXL
      for (int r = 0; r < 2; r++) begin
         int_req = 1; cp0_exl = (r == 1);
         if_valid = 1; if_pc = 32'h00400500; step(); clr_in();
         step(); step();
         mem_ades = 1; mem_badvaddr = 32'h10000003;
         wait_commit(); clr_in();
         check("t5_code", exc_code, (INT_EN && r == 0) ? 0 : 5);
         wait_redirect(nfl);
         int_req = 0; cp0_exl = 0; step();
      end

      // Reset in the middle of FLUSH
      if_valid = 1; if_pc = 32'h00400600; if_adel = 1; step(); clr_in();
      wait_commit();
      step(); rstn = 0; step(); rstn = 1;
      @(negedge clk);
      check("t6_rst_flush", flush, 0);
      check("t6_rst_busy", busy, 0);
      cnt = 0;
      for (int i = 0; i < 8; i++) begin @(negedge clk); if (redirect_valid) cnt++; end
      check("t6_no_redirect", cnt, 0);
      step();

      // Second exception presented while busy is ignored
      if_valid = 1; if_pc = 32'h00400700; if_adel = 1; step(); clr_in();
      wait_commit();
      step(); if_valid = 1; if_pc = 32'h00400800; if_adel = 1; mem_adel = 1; step(); clr_in();
      cnt = 0;
      for (int i = 0; i < 15; i++) begin @(negedge clk); if (exc_commit) cnt++; end
      check("t7_single_commit", cnt, 0);
      step();

      // Randomized traffic
      for (int c = 0; c < 4000; c++) begin
         if_valid = ($urandom_range(0, 9) < 7);
         if_pc    = {$urandom_range(0, 32'h3FFFFFFF), 2'b00};
         if_adel  = ($urandom_range(0, 31) == 0);
         id_ri    = ($urandom_range(0, 39) == 0);
         id_sys   = ($urandom_range(0, 39) == 0);
         id_bp    = ($urandom_range(0, 39) == 0);
         id_eret  = ($urandom_range(0, 29) == 0);
         id_in_ds = ($urandom_range(0, 3) == 0);
         ex_ov    = ($urandom_range(0, 39) == 0);
         mem_adel = ($urandom_range(0, 39) == 0);
         mem_ades = ($urandom_range(0, 39) == 0);
         mem_badvaddr = $urandom;
         stall    = ($urandom_range(0, 4) == 0);
         int_req  = ($urandom_range(0, 49) == 0);
         cp0_exl  = $urandom_range(0, 1);
         epc_in   = $urandom;
         rstn     = ($urandom_range(0, 499) != 0);
         step();
      end
      rstn = 1; clr_in(); int_req = 0;
      step(); step();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
